// File: rtl/axi_pkg.sv
// Shared types and defaults for the simplified AXI-style memory slave.
package axi_pkg;

   localparam int ADDR_W_DEF = 7;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      W_WAIT,
      W_DATA,
      W_RESP,
      R_WAIT,
      R_DATA
   } axi_slv_state_e;

   typedef logic [3:0] wait_cnt_t;

endpackage

// File: rtl/axi_mem_array.sv
// Word storage: synchronous write, combinational read, async active-low clear.
module axi_mem_array
   import axi_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Reset wipes every word; otherwise write on enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/axi_mem_slave.sv
// Single-outstanding AXI-style memory responder with programmable wait states.
module axi_mem_slave
   import axi_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int WR_WAIT = 0,
   parameter int RD_WAIT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic              aw_valid,
   output logic              aw_ready,
   input  logic              ar_valid,
   output logic              ar_ready,
   input  logic [DATA_W-1:0] write_data,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic              b_valid,
   input  logic              b_ready,
   output logic [DATA_W-1:0] read_data,
   output logic              rdata_valid,
   input  logic              rdata_ready
);

   localparam wait_cnt_t WR_WAIT_C = wait_cnt_t'(WR_WAIT);
   localparam wait_cnt_t RD_WAIT_C = wait_cnt_t'(RD_WAIT);

   axi_slv_state_e    state_q, state_d;
   wait_cnt_t         cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   axi_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk   (clk),
      .rst_n (reset),
      .we    (mem_we),
      .addr  (addr_q),
      .wdata (write_data),
      .rdata (mem_rdata)
   );

   // State, wait counter and latched address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
      end
   end

   // Next-state and output decode; only ar_ready looks at a live input.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      aw_ready    = 1'b0;
      ar_ready    = 1'b0;
      wdata_ready = 1'b0;
      b_valid     = 1'b0;
      rdata_valid = 1'b0;
      read_data   = '0;
      mem_we      = 1'b0;
      case (state_q)
         INIT: state_d = IDLE;
         IDLE: begin
            aw_ready = 1'b1;
            ar_ready = !aw_valid;
            if (aw_valid) begin
               addr_d  = mem_addr;
               cnt_d   = WR_WAIT_C;
               state_d = (WR_WAIT == 0) ? W_DATA : W_WAIT;
            end else if (ar_valid) begin
               addr_d  = mem_addr;
               cnt_d   = RD_WAIT_C;
               state_d = (RD_WAIT == 0) ? R_DATA : R_WAIT;
            end
         end
         // Counter was loaded with the wait count; leave on the cycle it reads 1.
         W_WAIT: begin
            if (cnt_q <= wait_cnt_t'(1)) state_d = W_DATA;
            else                         cnt_d   = cnt_q - 1'b1;
         end
         W_DATA: begin
            wdata_ready = 1'b1;
            if (wdata_valid) begin
               mem_we  = 1'b1;
               state_d = W_RESP;
            end
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (b_ready) state_d = IDLE;
         end
         R_WAIT: begin
            if (cnt_q <= wait_cnt_t'(1)) state_d = R_DATA;
            else                         cnt_d   = cnt_q - 1'b1;
         end
         R_DATA: begin
            rdata_valid = 1'b1;
            read_data   = mem_rdata;
            if (rdata_ready) state_d = IDLE;
         end
         default: state_d = INIT;
      endcase
   end

endmodule
